// File: rtl/riscv_pkg.sv
// Shared core definitions: NOP encoding, fetch FSM states
// and the IF/ID bundle.
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{
    valid: 1'b0,
    pc:    32'h0,
    instr: NOP
  };

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between
// the fetch stage (master) and instruction memory (slave).
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem
// request FSM, stall hold buffer and the IF/ID register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pcWrite,
  input  logic         IF_ID_Write,
  input  logic         flush,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic         if_id_valid,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_instr
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drop_pc;
  if_id_t       hold;
  if_id_t       if_id;

  logic         stall;
  logic         take;
  logic         adv;
  logic [31:0]  tgt;

  assign stall = ~pcWrite | ~IF_ID_Write;
  assign tgt   = redirect_pc & 32'hFFFF_FFFC;
  assign take  = (state == S_REQ) && imem.imem_ack;
  assign adv   = ~stall & (take | (state == S_HOLD));

  // DROP keeps presenting the abandoned address
  // until its response retires.
  assign imem.imem_req  = (state == S_REQ) ||
                          (state == S_DROP);
  assign imem.imem_addr = (state == S_DROP) ?
                          drop_pc : pc;

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      drop_pc <= 32'h0;
      hold    <= IF_ID_EMPTY;
      if_id   <= IF_ID_EMPTY;
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (flush)
            state <= imem.imem_ack ? S_REQ : S_DROP;
          else if (imem.imem_ack && stall)
            state <= S_HOLD;
        end
        S_HOLD: begin
          if (flush || !stall)
            state <= S_REQ;
        end
        S_DROP: begin
          if (imem.imem_ack)
            state <= S_REQ;
        end
      endcase

      if ((state == S_REQ) && flush && !imem.imem_ack)
        drop_pc <= pc;

      if (flush)
        hold <= IF_ID_EMPTY;
      else if (take && stall)
        hold <= '{1'b1, pc, imem.imem_rdata};

      if (flush)
        pc <= tgt;
      else if (adv)
        pc <= pc + 32'd4;

      if (flush) begin
        if_id.valid <= 1'b0;
        if_id.instr <= NOP;
      end else if (!stall) begin
        if (take)
          if_id <= '{1'b1, pc, imem.imem_rdata};
        else if (state == S_HOLD)
          if_id <= hold;
        else begin
          if_id.valid <= 1'b0;
          if_id.instr <= NOP;
        end
      end
    end
  end

endmodule
